// File: rtl/ifetch8.sv
// Two-byte instruction fetch unit: opcode then operand, held until the decoder
// takes it. MEM_ADDR follows the external PC, and INC advances that PC.
module ifetch8 (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  PC,
  output logic        INC,
  output logic [7:0]  MEM_ADDR,
  output logic        MEM_REQ,
  input  logic        MEM_ACK,
  input  logic [7:0]  MEM_DATA,
  output logic [15:0] IR,
  output logic        IR_VALID,
  input  logic        IR_READY,
  input  logic        FLUSH,
  output logic [7:0]  FETCH_CNT
);

  typedef enum logic [1:0] {
    OP_REQ  = 2'd0,
    ARG_REQ = 2'd1,
    HOLD    = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic        ir_valid_q, ir_valid_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        req;
  logic        take;

  assign MEM_ADDR  = PC;
  assign req       = (state_q != HOLD) & ~RST;
  assign MEM_REQ   = req;
  assign take      = req & MEM_ACK & ~FLUSH;
  assign INC       = take & ~RST;
  assign IR        = ir_q;
  assign IR_VALID  = ir_valid_q;
  assign FETCH_CNT = cnt_q;

  // FLUSH wins over byte acceptance and over the decoder handshake
  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    cnt_d      = cnt_q;
    if (FLUSH) begin
      state_d    = OP_REQ;
      ir_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        OP_REQ: begin
          if (MEM_ACK) begin
            ir_d[15:8] = MEM_DATA;
            state_d    = ARG_REQ;
          end
        end
        ARG_REQ: begin
          if (MEM_ACK) begin
            ir_d[7:0]  = MEM_DATA;
            ir_valid_d = 1'b1;
            state_d    = HOLD;
          end
        end
        HOLD: begin
          if (ir_valid_q && IR_READY) begin
            ir_valid_d = 1'b0;
            cnt_d      = cnt_q + 8'd1;
            state_d    = OP_REQ;
          end
        end
        default: begin
          state_d    = OP_REQ;
          ir_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= OP_REQ;
      ir_q       <= 16'h0000;
      ir_valid_q <= 1'b0;
      cnt_q      <= 8'h00;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule
